// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous bus target: decodes a mapped window, issues one backend request per hit,
// terminates with DTACK or BERR. Define M68K_RESP_AUTOVEC_EN to answer IACK cycles with VPA.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR      = 24'hF00000,
  parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
  parameter int          WAIT_STATES    = 2,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        s0rst,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [2:0]  fc,
  input  logic [22:0] addr,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_doe,
  output logic        dtack_oe,
  output logic        berr_oe,
  output logic        vpa_oe,
  output logic        be_req,
  output logic        be_we,
  output logic [1:0]  be_sel,
  output logic [22:0] be_adr,
  output logic [15:0] be_wdata,
  input  logic        be_ack,
  input  logic [15:0] be_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_REQ, S_ACK, S_ERR, S_TERM, S_VPA
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [15:0] bus_dout_q, bus_dout_d;
  logic        bus_doe_q, bus_doe_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;
  logic        be_req_q, be_req_d;
  logic        be_we_q, be_we_d;
  logic [1:0]  be_sel_q, be_sel_d;
  logic [22:0] be_adr_q, be_adr_d;
  logic [15:0] be_wdata_q, be_wdata_d;

  logic as_s, uds_s, lds_s, ds_any, win_hit, wait_done, to_done;

  // strobes sync as {as, uds, lds}; reset value is "negated"
  always_ff @(posedge clk or posedge s0rst) begin
    if (s0rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= {as_n, uds_n, lds_n};
      sync2_q <= sync1_q;
    end
  end

  assign as_s      = sync2_q[2];
  assign uds_s     = sync2_q[1];
  assign lds_s     = sync2_q[0];
  assign ds_any    = ~uds_s | ~lds_s;
  assign win_hit   = ((({addr, 1'b0}) & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)) && (fc != 3'b111);
  assign wait_done = ({1'b0, wait_cnt_q} + 5'd1) >= 5'(WAIT_STATES);
  assign to_done   = to_cnt_q == 8'(TIMEOUT_CYCLES - 1);

`ifdef M68K_RESP_AUTOVEC_EN
  logic vpa_q, vpa_d;
  logic iack;
  assign iack = (fc == 3'b111) && (addr[18:15] == 4'hF);
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    bus_dout_d = bus_dout_q;
    bus_doe_d  = bus_doe_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    be_req_d   = be_req_q;
    be_we_d    = be_we_q;
    be_sel_d   = be_sel_q;
    be_adr_d   = be_adr_q;
    be_wdata_d = be_wdata_q;
`ifdef M68K_RESP_AUTOVEC_EN
    vpa_d      = vpa_q;
`endif
    case (state_q)
      S_IDLE: if (!as_s) state_d = S_DECODE;
      S_DECODE: begin
        if (as_s) state_d = S_IDLE;
        else if (win_hit) begin
          // write strobes trail AS by a cycle: hold here until a DS shows up
          if (ds_any) begin
            be_adr_d   = addr;
            be_we_d    = ~rw;
            be_sel_d   = ~{uds_s, lds_s};
            if (!rw) be_wdata_d = bus_din;
            wait_cnt_d = 4'd0;
            state_d    = S_WAIT;
          end
        end
`ifdef M68K_RESP_AUTOVEC_EN
        else if (iack) begin
          if (ds_any) begin
            vpa_d   = 1'b1;
            state_d = S_VPA;
          end
        end
`endif
        else state_d = S_TERM;
      end
      S_WAIT: begin
        if (as_s) state_d = S_IDLE;
        else if (wait_done) begin
          be_req_d = 1'b1;
          to_cnt_d = 8'd0;
          state_d  = S_REQ;
        end else wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_REQ: begin
        if (as_s) begin
          be_req_d = 1'b0;
          state_d  = S_IDLE;
        end else if (be_ack) begin
          be_req_d  = 1'b0;
          if (rw) bus_dout_d = be_rdata;
          bus_doe_d = rw;
          dtack_d   = 1'b1;
          state_d   = S_ACK;
        end else if (to_done) begin
          be_req_d = 1'b0;
          berr_d   = 1'b1;
          state_d  = S_ERR;
        end else to_cnt_d = to_cnt_q + 8'd1;
      end
      S_ACK: if (as_s) begin
        dtack_d   = 1'b0;
        bus_doe_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_ERR: if (as_s) begin
        berr_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_TERM: if (as_s) state_d = S_IDLE;
`ifdef M68K_RESP_AUTOVEC_EN
      S_VPA: if (as_s) begin
        vpa_d   = 1'b0;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge s0rst) begin
    if (s0rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      bus_dout_q <= '0;
      bus_doe_q  <= 1'b0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      be_req_q   <= 1'b0;
      be_we_q    <= 1'b0;
      be_sel_q   <= '0;
      be_adr_q   <= '0;
      be_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bus_dout_q <= bus_dout_d;
      bus_doe_q  <= bus_doe_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      be_req_q   <= be_req_d;
      be_we_q    <= be_we_d;
      be_sel_q   <= be_sel_d;
      be_adr_q   <= be_adr_d;
      be_wdata_q <= be_wdata_d;
    end
  end

`ifdef M68K_RESP_AUTOVEC_EN
  always_ff @(posedge clk or posedge s0rst) begin
    if (s0rst) vpa_q <= 1'b0;
    else       vpa_q <= vpa_d;
  end
  assign vpa_oe = vpa_q;
`else
  assign vpa_oe = 1'b0;
`endif

  assign bus_dout = bus_dout_q;
  assign bus_doe  = bus_doe_q;
  assign dtack_oe = dtack_q;
  assign berr_oe  = berr_q;
  assign be_req   = be_req_q;
  assign be_we    = be_we_q;
  assign be_sel   = be_sel_q;
  assign be_adr   = be_adr_q;
  assign be_wdata = be_wdata_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Randomized bench for m68k_bus_responder: per-cycle bus master and backend, checked against
// transaction-level expectations (latencies, captured fields, termination kind).
module tb_m68k_bus_responder;
  localparam logic [23:0] BASE = 24'hF00000;
  localparam logic [23:0] MASK = 24'hFF0000;
  localparam int WS = 2;
  localparam int TO = 64;
  // 2 sync flops + IDLE->DECODE + DECODE->WAIT, then the wait states (at least one WAIT cycle)
  localparam int REQ_LAT = 4 + ((WS < 1) ? 1 : WS);
  localparam int K_HIT = 0, K_MISS = 1, K_ABORT = 2;
`ifdef M68K_RESP_AUTOVEC_EN
  localparam bit AV = 1'b1;
`else
  localparam bit AV = 1'b0;
`endif

  logic clk = 1'b0;
  logic s0rst, as_n, uds_n, lds_n, rw, be_ack;
  logic [2:0] fc;
  logic [22:0] addr, be_adr;
  logic [15:0] bus_din, bus_dout, be_wdata, be_rdata;
  logic bus_doe, dtack_oe, berr_oe, vpa_oe, be_req, be_we, busy;
  logic [1:0] be_sel;

  always #5 clk = ~clk;

  m68k_bus_responder #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .WAIT_STATES(WS),
                       .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .s0rst(s0rst), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw), .fc(fc),
    .addr(addr), .bus_din(bus_din), .bus_dout(bus_dout), .bus_doe(bus_doe),
    .dtack_oe(dtack_oe), .berr_oe(berr_oe), .vpa_oe(vpa_oe), .be_req(be_req), .be_we(be_we),
    .be_sel(be_sel), .be_adr(be_adr), .be_wdata(be_wdata), .be_ack(be_ack),
    .be_rdata(be_rdata), .busy(busy));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [22:0] a, input logic [2:0] f);
    return ((({a, 1'b0}) & MASK) == (BASE & MASK)) && (f != 3'b111);
  endfunction

  function automatic bit is_iack(input logic [22:0] a, input logic [2:0] f);
    return (f == 3'b111) && (a[18:15] == 4'hF);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full bus cycle; sample times t count clock edges since AS went low at the pin.
  task automatic txn(input int kind, input logic [22:0] a, input logic [2:0] f, input logic r,
                     input logic [1:0] sel, input logic [15:0] wd, input logic [15:0] rd,
                     input int ack_d, input int ab_at, input bit ds_lag);
    int req_t = -1, req_n = 0, dt_t = -1, be_t = -1, vpa_t = -1, end_t = -1;
    int exp_vpa;
    addr = a; fc = f; rw = r; bus_din = wd; as_n = 1'b0;
    if (!ds_lag) {uds_n, lds_n} = ~sel;
    for (int t = 1; t <= 120; t++) begin
      @(posedge clk);
      #1;
      if (t == 1) {uds_n, lds_n} = ~sel;
      be_ack = 1'b0;
      be_rdata = 16'($urandom);
      if (be_req) begin
        if (req_t < 0) begin
          req_t = t;
          chk("be_adr", be_adr, a);
          chk("be_we", be_we, !r);
          chk("be_sel", be_sel, sel);
          if (!r) chk("be_wdata", be_wdata, wd);
        end
        req_n++;
        if (req_n == ack_d) begin
          be_ack = 1'b1;
          be_rdata = rd;
        end
      end
      if (dtack_oe && dt_t < 0) begin
        dt_t = t;
        chk("bus_doe", bus_doe, r);
        if (r) chk("bus_dout", bus_dout, rd);
      end
      if (berr_oe && be_t < 0) be_t = t;
      if (vpa_oe && vpa_t < 0) vpa_t = t;
      if (end_t < 0 && (dt_t == t || be_t == t || vpa_t == t ||
                        (kind == K_MISS && t == 8) || (kind == K_ABORT && t == ab_at))) begin
        end_t = t;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      end
      if (end_t > 0 && t == end_t + 3) break;
    end
    be_ack = 1'b0;
    chk("ended", end_t >= 0, 1);
    chk("end_busy", busy, 0);
    chk("end_dtack", dtack_oe, 0);
    chk("end_doe", bus_doe, 0);
    chk("end_berr", berr_oe, 0);
    chk("end_vpa", vpa_oe, 0);
    chk("end_req", be_req, 0);
    if (kind == K_HIT) begin
      chk("req_lat", req_t, REQ_LAT);
      if (ack_d <= TO) begin
        chk("req_len", req_n, ack_d);
        chk("dtack_t", dt_t, req_t + ack_d);
        chk("no_berr", be_t, -1);
      end else begin
        chk("req_len_to", req_n, TO);
        chk("berr_t", be_t, req_t + TO);
        chk("no_dtack", dt_t, -1);
      end
    end else begin
      exp_vpa = (kind == K_MISS && AV && is_iack(a, f)) ? 4 : -1;
      chk("vpa_t", vpa_t, exp_vpa);
      chk("nd_dtack", dt_t, -1);
      chk("nd_berr", be_t, -1);
      if (kind == K_MISS || ab_at <= 3) chk("no_req", req_t, -1);
    end
    step(2);
  endtask

  initial begin
    logic [22:0] a;
    logic [2:0] f;
    logic [1:0] sel;
    logic r;
    bit seen;
    s0rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; fc = 3'b000;
    addr = '0; bus_din = '0; be_ack = 1'b0; be_rdata = '0;
    step(3);
    chk("rst_outs", {bus_doe, dtack_oe, berr_oe, vpa_oe, be_req, be_we, busy}, 0);
    chk("rst_data", {bus_dout, be_wdata}, 0);
    chk("rst_sel_adr", {be_sel, be_adr}, 0);
    s0rst = 1'b0;
    step(2);

    // directed cases
    txn(K_HIT, 23'h780010, 3'b101, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 3, 0, 1'b0);
    txn(K_HIT, 23'h780020, 3'b001, 1'b0, 2'b10, 16'h5A00, 16'h0000, 2, 0, 1'b1);
    txn(K_HIT, 23'h780030, 3'b101, 1'b1, 2'b11, 16'h0000, 16'h0000, 1000, 0, 1'b0);
    txn(K_HIT, 23'h780032, 3'b101, 1'b1, 2'b01, 16'h0000, 16'hC0DE, TO, 0, 1'b0);
    txn(K_MISS, 23'h000100, 3'b101, 1'b1, 2'b11, 16'h0000, 16'h0000, 1, 0, 1'b0);
    txn(K_MISS, 23'h780010, 3'b111, 1'b1, 2'b11, 16'h0000, 16'h0000, 1, 0, 1'b0);
    txn(K_MISS, 23'h078000, 3'b111, 1'b1, 2'b01, 16'h0000, 16'h0000, 1, 0, 1'b0);
    txn(K_ABORT, 23'h780040, 3'b101, 1'b1, 2'b11, 16'h0000, 16'h0000, 1000, 3, 1'b0);
    txn(K_ABORT, 23'h780042, 3'b101, 1'b0, 2'b11, 16'h1111, 16'h0000, 1000, 10, 1'b0);

    // stray ack while idle must not start anything
    be_ack = 1'b1; be_rdata = 16'hDEAD;
    step(1);
    be_ack = 1'b0;
    step(1);
    chk("late_ack_dtack", dtack_oe, 0);
    chk("late_ack_busy", busy, 0);

    // reset while DTACK is being driven
    addr = 23'h780044; fc = 3'b101; rw = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step(1);
      be_ack = be_req;
      be_rdata = 16'h1234;
      if (dtack_oe) seen = 1'b1;
    end
    chk("rst_reach_ack", seen, 1);
    #2 s0rst = 1'b1;
    #1;
    chk("midrst_dtack", dtack_oe, 0);
    chk("midrst_doe", bus_doe, 0);
    chk("midrst_req", be_req, 0);
    chk("midrst_busy", busy, 0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; be_ack = 1'b0;
    step(1);
    s0rst = 1'b0;
    step(1);
    txn(K_HIT, 23'h780046, 3'b101, 1'b1, 2'b11, 16'h0000, 16'h7E57, 2, 0, 1'b0);

    // randomized cycles
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      a = {8'hF0, 15'($urandom)};
      f = 3'($urandom_range(0, 6));
      sel = 2'($urandom_range(1, 3));
      r = 1'($urandom);
      if (k < 5)
        txn(K_HIT, a, f, r, sel, 16'($urandom), 16'($urandom), $urandom_range(1, 8), 0,
            r ? 1'b0 : 1'($urandom));
      else if (k == 5)
        txn(K_HIT, a, f, r, sel, 16'($urandom), 16'($urandom), $urandom_range(60, 70), 0, 1'b0);
      else if (k == 6) begin
        a = {8'($urandom), 15'($urandom)};
        if (a[22:15] == 8'hF0) a[22] = 1'b0;
        txn(K_MISS, a, f, r, sel, 16'($urandom), 16'h0, 1, 0, 1'b0);
      end else if (k == 7)
        txn(K_MISS, {4'($urandom), 4'hF, 15'($urandom)}, 3'b111, 1'b1, sel, 16'h0, 16'h0, 1, 0,
            1'b0);
      else
        txn(K_ABORT, a, f, r, sel, 16'($urandom), 16'h0, 1000,
            (k == 8) ? 3 : $urandom_range(7, 30), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- 68000 asynchronous bus target: the responder end of the cycle the PiStorm-Atari CPLD initiates.
- Decodes AS/UDS/LDS/RW/FC/address against a mapped window and converts each hit into a single-request backend handshake (register file / SRAM).
- Terminates the bus cycle with DTACK, or with BERR on backend timeout.
- Serves as a bench responder for the bus master and as a reusable peripheral front-end on the expansion bus.

Parameters:
- BASE_ADDR, 24'hF00000, window base; byte address, bit 0 ignored.
- ADDR_MASK, 24'hFF0000, compare mask; hit when (addr & mask) == (BASE_ADDR & mask).
- WAIT_STATES, 2, extra clk cycles inserted after decode before backend request; 0..15.
- TIMEOUT_CYCLES, 64, clk cycles allowed for backend ack before BERR; 2..255.

Ports:
- clk  in  1  68K bus clock (C8M).
- s0rst  in  1  reset: asynchronous, active-high.
- as_n  in  1  address strobe.
- uds_n  in  1  upper data strobe.
- lds_n  in  1  lower data strobe.
- rw  in  1  1 = read, 0 = write.
- fc  in  3  function code.
- addr  in  23  A[23:1].
- bus_din  in  16  data bus as seen on pins.
- bus_dout  out  16  read data to bus.
- bus_doe  out  1  data bus output enable.
- dtack_oe  out  1  pull DTACK_n low.
- berr_oe  out  1  pull BERR_n low.
- vpa_oe  out  1  pull VPA_n low; see optional feature.
- be_req  out  1  backend request.
- be_we  out  1  backend write.
- be_sel  out  2  byte enables {upper, lower}.
- be_adr  out  23  backend word address.
- be_wdata  out  16  backend write data.
- be_ack  in  1  backend acknowledge, single-cycle pulse.
- be_rdata  in  16  backend read data, valid with be_ack.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs reset to 0 asynchronously on s0rst. State goes to IDLE. Counters clear.
- as_n, uds_n and lds_n pass through a 2-flop synchroniser on posedge clk. All state logic uses the synchronised copies (as_s, ds_s).
- addr, fc, rw and bus_din are captured directly in the state that consumes them; they are stable while AS is low.
- IDLE -> DECODE when as_s is low.
- DECODE:
  - On a window hit with any ds_s low: capture be_adr = addr, be_we = ~rw, be_sel = ~{uds, lds}, be_wdata = bus_din (writes only), then go to WAIT.
  - On a window hit with both ds_s high: stay in DECODE. Write DS arrives a cycle after AS.
  - On a miss: go to TERM and drive nothing.
- WAIT: count WAIT_STATES cycles, then go to REQ. With WAIT_STATES = 0 the move is next cycle.
- REQ:
  - be_req is held high until be_ack. The timeout counter starts at 0 on entry.
  - On be_ack: be_req = 0; for reads, bus_dout = be_rdata; go to ACK.
  - When the counter reaches TIMEOUT_CYCLES-1 without be_ack: be_req = 0, go to ERR.
  - If be_ack and timeout coincide, be_ack wins.
- ACK: dtack_oe = 1, and bus_doe = rw. Both are registered, asserted the cycle after be_ack. Hold until as_s goes high, then go to IDLE. dtack_oe and bus_doe drop in the same cycle.
- ERR: berr_oe = 1 until as_s goes high, then go to IDLE. dtack_oe and bus_doe are never asserted in ERR.
- TERM: drive nothing; wait for as_s high, then go to IDLE.
- Abort: as_s high in DECODE, WAIT or REQ forces IDLE next cycle with be_req = 0. The backend must discard an unacked request. A late be_ack in IDLE is ignored.
- Back-to-back cycles: a new cycle is accepted only after IDLE has been visited for at least 1 cycle.
- Byte enables: be_sel = 2'b00 never reaches the backend.
- The FC 3'b111 CPU-space cycle is treated as a miss unless the optional feature is compiled in.

Optional Feature:
- Macro M68K_RESP_AUTOVEC_EN.
- When defined, a CPU-space interrupt-acknowledge cycle (fc = 3'b111, A[19:16] = 4'hF, any DS low) is answered as follows:
  - vpa_oe = 1 from the cycle after DECODE until as_s goes high.
  - No backend request, no DTACK.
  - This produces a 68000 autovector, matching the IPL reporting of the bus master.
- When undefined, vpa_oe is tied to 0 and such cycles take the miss path (TERM).

Test Plan:
- Read hit: AS/UDS/LDS low, rw = 1, addr = 23'h780010 (byte F00020), WAIT_STATES = 2, backend acks with 16'hBEEF 3 cycles after be_req -> be_sel = 2'b11, be_we = 0, dtack_oe and bus_doe high the cycle after be_ack with bus_dout = 16'hBEEF, both low the cycle after as_s high.
- Byte write: rw = 0, UDS low one cycle after AS, LDS high, bus_din = 16'h5A00 -> be_we = 1, be_sel = 2'b10, be_wdata = 16'h5A00, DTACK after ack.
- Timeout: backend never acks, TIMEOUT_CYCLES = 64 -> be_req high for exactly 64 cycles, then berr_oe = 1, dtack_oe stays 0, IDLE after AS negation.
- Miss and abort: addr = 23'h000100 -> no be_req and no strobes driven. Separately, a hit with AS negated during WAIT -> be_req never asserted, busy low within 3 cycles of AS at the pin.
- Reset mid-cycle: s0rst pulsed while in ACK -> dtack_oe, bus_doe, be_req and busy are 0 immediately; the next cycle decodes normally.
- Autovector (macro defined): fc = 3'b111, A[19:16] = 4'hF -> vpa_oe = 1, no be_req. With the macro undefined -> vpa_oe stays 0.
